// File: rtl/instr_aligner_if.sv
// rtl/instr_aligner_if.sv - fetch-word in / instruction out handshake bundle for instr_aligner
interface instr_aligner_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] fetch_data_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    modport slave (
        input  flush_i, flush_pc_i, fetch_data_i, fetch_valid_i, instr_ready_i,
        output fetch_ready_o, instr_o, instr_pc_o, instr_valid_o
    );

    modport master (
        output flush_i, flush_pc_i, fetch_data_i, fetch_valid_i, instr_ready_i,
        input  fetch_ready_o, instr_o, instr_pc_o, instr_valid_o
    );
endinterface

// File: rtl/instr_aligner.sv
// rtl/instr_aligner.sv - splits word-aligned fetch words into 16/32-bit instructions with PCs
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    instr_aligner_if.slave bus
);
    logic [15:0] hw   [3];
    logic [15:0] hw_n [3];
    logic [1:0]  cnt, cnt_n, rem, n_cons;
    logic [31:0] pc, pc_n;
    logic        drop, drop_n;
    logic        is32, consume, accept;

    assign is32 = (hw[0][1:0] == 2'b11);

    assign bus.instr_valid_o = !bus.flush_i &
                               (((cnt >= 2'd1) & !is32) | ((cnt >= 2'd2) & is32));
    assign bus.instr_o       = is32 ? {hw[1], hw[0]} : {16'h0000, hw[0]};
    assign bus.instr_pc_o    = pc;
    // Ready looks only at the halfword count so it never depends on the consumer.
    assign bus.fetch_ready_o = (cnt <= 2'd1);

    assign consume = bus.instr_valid_o & bus.instr_ready_i;
    assign accept  = bus.fetch_valid_i & bus.fetch_ready_o & !bus.flush_i;
    assign n_cons  = consume ? (is32 ? 2'd2 : 2'd1) : 2'd0;

    always_comb begin
        hw_n   = hw;
        rem    = cnt - n_cons;
        cnt_n  = rem;
        drop_n = drop;
        pc_n   = pc + (consume ? (is32 ? 32'd4 : 32'd2) : 32'd0);

        if (n_cons == 2'd1) begin
            hw_n[0] = hw[1];
            hw_n[1] = hw[2];
        end else if (n_cons == 2'd2) begin
            hw_n[0] = hw[2];
        end

        // Accept only happens with cnt<=1, so rem<=1 and both slots fit.
        if (accept) begin
            if (drop) begin
                hw_n[rem] = bus.fetch_data_i[31:16];
                cnt_n     = rem + 2'd1;
                drop_n    = 1'b0;
            end else begin
                hw_n[rem]        = bus.fetch_data_i[15:0];
                hw_n[rem + 2'd1] = bus.fetch_data_i[31:16];
                cnt_n            = rem + 2'd2;
            end
        end

        if (bus.flush_i) begin
            cnt_n  = 2'd0;
            pc_n   = bus.flush_pc_i & 32'hFFFF_FFFE;
            drop_n = bus.flush_pc_i[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt   <= 2'd0;
            pc    <= RESET_PC;
            drop  <= RESET_PC[1];
            hw[0] <= 16'h0000;
            hw[1] <= 16'h0000;
            hw[2] <= 16'h0000;
        end else begin
            cnt   <= cnt_n;
            pc    <= pc_n;
            drop  <= drop_n;
            hw[0] <= hw_n[0];
            hw[1] <= hw_n[1];
            hw[2] <= hw_n[2];
        end
    end
endmodule
